// File: rtl/atomx_mac_unit.sv
// Sequential 16x16 unsigned shift-add multiply-accumulate unit for the Atom X extension.
// Optional accumulator saturation with a sticky overflow flag: define ATOMX_MAC_SAT_EN.
module atomx_mac_unit #(
    parameter int unsigned ITER  = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [ITER-1:0]  a_i,
    input  logic [ITER-1:0]  b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] result_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    localparam int unsigned CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MAC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_READ = 2'b11
    } op_t;

    state_t            state;
    op_t               op_q;
    logic [ACC_W-1:0]  mcand;
    logic [ITER-1:0]   mplier;
    logic [ACC_W-1:0]  pp;
    logic [CW-1:0]     cnt;

`ifdef ATOMX_MAC_SAT_EN
    logic [ACC_W:0]    mac_sum;

    always_comb begin
        mac_sum = {1'b0, acc_o} + {1'b0, pp};
    end
`else
    assign ovf_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            op_q     <= OP_MUL;
            mcand    <= '0;
            mplier   <= '0;
            pp       <= '0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            acc_o    <= '0;
`ifdef ATOMX_MAC_SAT_EN
            ovf_o    <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_o <= 1'b0;
                    // The done_o cycle is spent in IDLE with busy_o still high,
                    // so a start seen during it must not be taken.
                    if (start_i && !done_o) begin
                        busy_o <= 1'b1;
                        op_q   <= op_t'(op_i);
                        mcand  <= {{(ACC_W-ITER){1'b0}}, a_i};
                        mplier <= b_i;
                        pp     <= '0;
                        cnt    <= '0;
                        if (op_i == OP_MUL || op_i == OP_MAC)
                            state <= S_RUN;
                        else
                            state <= S_DONE;
                    end
                end
                S_RUN: begin
                    if (mplier[0])
                        pp <= pp + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    state  <= S_IDLE;
                    case (op_q)
                        OP_MUL: result_o <= pp;
                        OP_MAC: begin
`ifdef ATOMX_MAC_SAT_EN
                            if (mac_sum[ACC_W]) begin
                                acc_o    <= '1;
                                result_o <= '1;
                                ovf_o    <= 1'b1;
                            end else begin
                                acc_o    <= mac_sum[ACC_W-1:0];
                                result_o <= mac_sum[ACC_W-1:0];
                            end
`else
                            acc_o    <= acc_o + pp;
                            result_o <= acc_o + pp;
`endif
                        end
                        OP_CLR: begin
                            acc_o    <= '0;
                            result_o <= '0;
`ifdef ATOMX_MAC_SAT_EN
                            ovf_o    <= 1'b0;
`endif
                        end
                        default: result_o <= acc_o;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atomx_mac_unit.sv
// Self-checking bench for atomx_mac_unit: directed vector table, hand-written
// corner sequences, and randomized operations against an arithmetic reference model.
module tb_atomx_mac_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [31:0] acc_o;
    logic        ovf_o;

    int n_cmp = 0;
    int n_bad = 0;

    atomx_mac_unit #(.ITER(16), .ACC_W(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .acc_o    (acc_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        bit          poke;
        logic [31:0] res;
        logic [31:0] acc;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    // reference model state
    logic [31:0] m_acc;
    logic        m_ovf;

`ifdef ATOMX_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] res, output int lat);
        longint unsigned prod, sum;
        prod = longint'(a) * longint'(b);
        lat  = (op < 2) ? 17 : 1;
        case (op)
            2'd0: res = prod[31:0];
            2'd1: begin
                sum = longint'(m_acc) + prod;
                if (SAT && sum > 64'hFFFF_FFFF) begin
                    m_acc = 32'hFFFF_FFFF;
                    m_ovf = 1'b1;
                end else begin
                    m_acc = sum[31:0];
                end
                res = m_acc;
            end
            2'd2: begin
                m_acc = 0;
                m_ovf = 0;
                res   = 0;
            end
            default: res = m_acc;
        endcase
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit poke, output logic [31:0] res, output logic [31:0] acc,
                         output logic ovf, output int lat);
        int  n;
        bit  seen;
        bit  busy_ok;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_i     = 16'($urandom);
        b_i     = 16'($urandom);
        op_i    = 2'($urandom);
        busy_ok = busy_o;
        seen    = 1'b0;
        lat     = -1;
        n       = 0;
        while (!seen && n < 40) begin
            if (poke && n == 4) start_i = 1'b1;
            if (poke && n == 6) start_i = 1'b0;
            @(posedge clk_i); #1;
            n++;
            if (!busy_o) busy_ok = 1'b0;
            if (done_o) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        start_i = 1'b0;
        res = result_o;
        acc = acc_o;
        ovf = ovf_o;
        chk("busy_held", 32'(busy_ok), 32'd1);
        @(posedge clk_i); #1;
        chk("done_single", 32'(done_o), 32'd0);
        chk("busy_released", 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] res, acc, e_res;
        logic        ovf;
        int          lat, e_lat, ndone;
        logic [1:0]  op;
        logic [15:0] a, b;

        tbl[0]  = '{2'd0, 16'h1234, 16'h0056, 1'b0, 32'h0006_1D78, 32'h0, 1'b0, 17};
        tbl[1]  = '{2'd1, 16'h0003, 16'h0004, 1'b0, 32'h0000_000C, 32'h0000_000C, 1'b0, 17};
        tbl[2]  = '{2'd1, 16'h0005, 16'h0006, 1'b0, 32'h0000_002A, 32'h0000_002A, 1'b0, 17};
        tbl[3]  = '{2'd3, 16'h0000, 16'h0000, 1'b0, 32'h0000_002A, 32'h0000_002A, 1'b0, 1};
        tbl[4]  = '{2'd0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 32'h0000_002A, 1'b0, 17};
        tbl[5]  = '{2'd2, 16'h1111, 16'h2222, 1'b0, 32'h0, 32'h0, 1'b0, 1};
        tbl[6]  = '{2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 32'hFFFE_0001, 1'b0, 17};
`ifdef ATOMX_MAC_SAT_EN
        tbl[7]  = '{2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 17};
        tbl[8]  = '{2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 17};
`else
        tbl[7]  = '{2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFC_0002, 32'hFFFC_0002, 1'b0, 17};
        tbl[8]  = '{2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFA_0003, 32'hFFFA_0003, 1'b0, 17};
`endif
        tbl[9]  = '{2'd2, 16'h0000, 16'h0000, 1'b0, 32'h0, 32'h0, 1'b0, 1};
        tbl[10] = '{2'd3, 16'h0000, 16'h0000, 1'b0, 32'h0, 32'h0, 1'b0, 1};

        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'd0;
        a_i     = 16'h0;
        b_i     = 16'h0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_busy",   32'(busy_o), 32'd0);
        chk("rst_done",   32'(done_o), 32'd0);
        chk("rst_result", result_o,    32'd0);
        chk("rst_acc",    acc_o,       32'd0);
        chk("rst_ovf",    32'(ovf_o),  32'd0);

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].poke, res, acc, ovf, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].res);
            chk($sformatf("vec%0d_acc", i), acc, tbl[i].acc);
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
        end

        m_acc = 32'h0;
        m_ovf = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd2 && $urandom_range(0, 2) != 0) op = 2'd1;
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            model(op, a, b, e_res, e_lat);
            do_op(op, a, b, 1'b0, res, acc, ovf, lat);
            chk($sformatf("rnd%0d_result", i), res, e_res);
            chk($sformatf("rnd%0d_acc", i), acc, m_acc);
            chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(m_ovf));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(e_lat));
        end

        // make the accumulator non-zero so the reset clear is observable
        m_acc = 32'h0;
        do_op(2'd2, 16'h0, 16'h0, 1'b0, res, acc, ovf, lat);
        do_op(2'd1, 16'h0100, 16'h0100, 1'b0, res, acc, ovf, lat);
        chk("pre_reset_acc", acc, 32'h0001_0000);

        start_i = 1'b1;
        op_i    = 2'd1;
        a_i     = 16'h0007;
        b_i     = 16'h0009;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_busy",   32'(busy_o), 32'd0);
        chk("midrst_done",   32'(done_o), 32'd0);
        chk("midrst_result", result_o,    32'd0);
        chk("midrst_acc",    acc_o,       32'd0);
        chk("midrst_ovf",    32'(ovf_o),  32'd0);
        ndone = 0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (done_o) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        do_op(2'd0, 16'h0002, 16'h0003, 1'b0, res, acc, ovf, lat);
        chk("postrst_result",  res,        32'd6);
        chk("postrst_acc",     acc,        32'd0);
        chk("postrst_latency", 32'(lat),   32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/atomx_mac_unit.md
Name: atomx_mac_unit

Overview:
- Sequential multiply-accumulate unit for the Atom core's approximate-arithmetic (X) extension.
- Sits directly downstream of the ALU's X path. The ALU supplies the operands; this block holds the 32-bit accumulator, which the ALU's combinational datapath cannot hold.
- Computes an unsigned 16x16 product with a radix-2 shift-add over 16 cycles. The product is returned directly (MUL) or added into the accumulator (MAC).
- Issued by the execute stage through a start/busy/done handshake; the core stalls while busy_o is high.

Parameters:
- ITER, 16, number of shift-add iterations; equals operand width and must stay 16.
- ACC_W, 32, accumulator and result width.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  request strobe; sampled only in IDLE
- op_i  input  2  operation select: 00 MUL, 01 MAC, 10 CLR, 11 READ
- a_i  input  16  multiplicand, unsigned
- b_i  input  16  multiplier, unsigned
- busy_o  output  1  high in RUN and DONE
- done_o  output  1  one-cycle completion pulse
- result_o  output  32  result of the last operation; held until the next completion
- acc_o  output  32  live accumulator value
- ovf_o  output  1  sticky accumulator overflow flag; see Optional Feature

Behaviour:
- Decided interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - state = IDLE.
  - busy_o, done_o and ovf_o = 0.
  - result_o and acc_o = 0.
  - Internal counter, partial product and operand registers = 0.
- Reset asserted mid-operation aborts the operation. No done_o pulse is produced and the accumulator is cleared.
- States:
  - IDLE: if start_i = 1, latch op_i, a_i and b_i. For MUL or MAC go to RUN with partial product = 0 and count = 0. For CLR or READ go straight to DONE.
  - RUN: each cycle, if bit 0 of the shifted multiplier is 1, add the shifted multiplicand into the 32-bit partial product. Then shift the multiplicand left 1, shift the multiplier right 1 and increment count. After the iteration with count = 15, go to DONE.
  - DONE: commit the result, pulse done_o, then return to IDLE.
- Commit actions in DONE:
  - MUL: result_o = product; accumulator unchanged.
  - MAC: accumulator = accumulator + product; result_o = new accumulator value.
  - CLR: accumulator = 0; result_o = 0; ovf_o cleared.
  - READ: result_o = accumulator.
- Latency, counted from the rising edge that samples start_i high:
  - MUL/MAC: done_o is high during the cycle following edge +17.
  - CLR/READ: done_o is high during the cycle following edge +1.
- busy_o is high from the cycle after acceptance through the done_o cycle inclusive.
- A new start_i may be accepted in the cycle after done_o (IDLE). start_i while busy_o = 1 is ignored and not queued.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Arithmetic: the product is exact and unsigned, at most 0xFFFE0001. The accumulator adds modulo 2^32 unless the Optional Feature is enabled.
- acc_o updates in the same cycle as done_o.

Optional Feature:
- Macro: ATOMX_MAC_SAT_EN.
- When defined:
  - A MAC addition whose 33-bit sum exceeds 0xFFFFFFFF clamps the accumulator to 0xFFFFFFFF.
  - ovf_o is set and stays set until a CLR or reset.
- When undefined:
  - The accumulator wraps modulo 2^32.
  - ovf_o is tied to 0.
  - No saturation logic is synthesised.

Test Plan:
- Reset then MUL a=0x1234, b=0x0056 -> done_o pulses exactly 17 cycles after acceptance; result_o = 0x00061D78; acc_o stays 0.
- MAC 3x4, then MAC 5x6, then READ -> result_o = 0x0C, then 0x2A, then READ returns 0x2A; READ done_o comes 1 cycle after acceptance.
- MUL 0xFFFF x 0xFFFF -> result_o = 0xFFFE0001; start_i pulsed during RUN is ignored and busy_o stays high throughout.
- Accumulator preloaded by two MAC 0xFFFF x 0xFFFF, then a third -> with ATOMX_MAC_SAT_EN, acc_o = 0xFFFFFFFF and ovf_o = 1. Without it, acc_o = 0xFFFA0003 and ovf_o = 0. In both builds, a following CLR gives acc_o = 0 and ovf_o = 0.
- rst_i asserted 8 cycles into a MAC -> next cycle all outputs are 0; no done_o pulse; a new MUL 2x3 is accepted and returns 6.
